// File: rtl/half_fixed_layer_sequencer.sv
// Sequencer for one half_fixed_matrix_dot_vector layer: streams the weight
// matrix in, then buffers and issues input vectors, and forwards row results.
module half_fixed_layer_sequencer #(
  parameter int BITS   = 16,
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 10,
  parameter int MULTS  = 2,
  localparam int BEATS  = WIDTH / MULTS,
  localparam int LBEATS = HEIGHT * BEATS,
  localparam int AW     = $clog2(LBEATS),
  localparam int KW     = $clog2(BEATS),
  localparam int IW     = $clog2(HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 n_vectors,
  output logic                        busy,
  output logic                        done,
  output logic                        w_rd_en,
  output logic [AW-1:0]               w_addr,
  input  logic [MULTS-1:0][BITS-1:0]  w_data,
  input  logic                        vec_valid,
  output logic                        vec_ready,
  input  logic [MULTS-1:0][BITS-1:0]  vec_data,
  output logic                        dp_load_matrix,
  output logic [MULTS-1:0][BITS-1:0]  dp_matrix_a,
  output logic                        dp_in_valid,
  output logic [MULTS-1:0][BITS-1:0]  dp_vector_b,
  input  logic                        dp_out_valid,
  input  logic [BITS-1:0]             dp_c,
  output logic                        res_valid,
  output logic [BITS-1:0]             res_data,
  output logic [IW-1:0]               res_index
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, ISSUE, DRAIN} state_t;

  state_t                     state;
  logic [MULTS-1:0][BITS-1:0] vbuf [BEATS];
  logic [KW-1:0]              k;
  logic [15:0]                n_cap;
  logic [15:0]                remaining;
  logic [31:0]                res_cnt;
  logic [31:0]                res_cnt_next;
  logic [31:0]                target;

  // Memory data arrives one cycle after the address, aligned with dp_load_matrix.
  assign dp_matrix_a  = dp_load_matrix ? w_data : '0;
  assign target       = 32'(n_cap) * 32'(HEIGHT);
  assign res_cnt_next = res_cnt + ((busy && res_valid) ? 32'd1 : 32'd0);

  always_ff @(posedge clk) begin
    if (state == FILL && vec_valid && vec_ready) vbuf[k] <= vec_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_rd_en        <= 1'b0;
      w_addr         <= '0;
      vec_ready      <= 1'b0;
      dp_load_matrix <= 1'b0;
      dp_in_valid    <= 1'b0;
      dp_vector_b    <= '0;
      k              <= '0;
      n_cap          <= '0;
      remaining      <= '0;
      res_cnt        <= '0;
    end else begin
      dp_load_matrix <= w_rd_en;
      done           <= 1'b0;
      if (busy && res_valid) res_cnt <= res_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            n_cap     <= n_vectors;
            remaining <= n_vectors;
            res_cnt   <= '0;
            k         <= '0;
            w_rd_en   <= 1'b1;
            w_addr    <= '0;
          end
        end
        LOAD: begin
          if (w_addr == AW'(LBEATS - 1)) begin
            w_rd_en <= 1'b0;
            w_addr  <= '0;
            state   <= (remaining == '0) ? DRAIN : FILL;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        FILL: begin
          vec_ready <= 1'b1;
          if (vec_valid && vec_ready) begin
            if (k == KW'(BEATS - 1)) begin
              vec_ready   <= 1'b0;
              state       <= ISSUE;
              k           <= '0;
              dp_in_valid <= 1'b1;
              dp_vector_b <= vbuf[0];
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (k == KW'(BEATS - 1)) begin
            dp_in_valid <= 1'b0;
            dp_vector_b <= '0;
            k           <= '0;
            remaining   <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= DRAIN;
            end else begin
              state     <= FILL;
              vec_ready <= 1'b1;
            end
          end else begin
            k           <= k + 1'b1;
            dp_vector_b <= vbuf[k + 1'b1];
          end
        end
        DRAIN: begin
          // Hold off until the load pipe has emptied so an empty run still ends cleanly.
          if (!dp_load_matrix && res_cnt_next == target) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      res_valid <= dp_out_valid;
      res_data  <= dp_c;
      if (res_valid) res_index <= (res_index == IW'(HEIGHT - 1)) ? '0 : res_index + 1'b1;
    end
  end

endmodule

// File: tb/tb_half_fixed_layer_sequencer.sv
// Bench for half_fixed_layer_sequencer: weight ROM, behavioural datapath,
// vector driver and a result scoreboard.
module tb_half_fixed_layer_sequencer;
  localparam int BITS   = 16;
  localparam int WIDTH  = 40;
  localparam int HEIGHT = 10;
  localparam int MULTS  = 2;
  localparam int BEATS  = WIDTH / MULTS;
  localparam int LBEATS = HEIGHT * BEATS;
  localparam int AW     = $clog2(LBEATS);
  localparam int KW     = $clog2(BEATS);
  localparam int IW     = $clog2(HEIGHT);

  typedef logic [MULTS-1:0][BITS-1:0] beat_t;
  typedef struct { logic [BITS-1:0] data; int idx; } res_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [15:0]     n_vectors = '0;
  logic            busy, done, w_rd_en;
  logic [AW-1:0]   w_addr;
  beat_t           w_data = '0;
  logic            vec_valid = 1'b0;
  logic            vec_ready;
  beat_t           vec_data = '0;
  logic            dp_load_matrix, dp_in_valid;
  beat_t           dp_matrix_a, dp_vector_b;
  logic            dp_out_valid = 1'b0;
  logic [BITS-1:0] dp_c = '0;
  logic            res_valid;
  logic [BITS-1:0] res_data;
  logic [IW-1:0]   res_index;

  half_fixed_layer_sequencer #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MULTS(MULTS)) dut (
    .clk(clk), .rst(rst), .start(start), .n_vectors(n_vectors),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .dp_load_matrix(dp_load_matrix), .dp_matrix_a(dp_matrix_a),
    .dp_in_valid(dp_in_valid), .dp_vector_b(dp_vector_b),
    .dp_out_valid(dp_out_valid), .dp_c(dp_c),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Weight memory: 1.0 (Q8.8) on the diagonal, one-cycle read latency.
  beat_t wmem [LBEATS];
  initial begin
    for (int i = 0; i < LBEATS; i++) wmem[i] = '0;
    for (int r = 0; r < HEIGHT; r++) wmem[r * BEATS + r / MULTS][r % MULTS] = 16'h0100;
  end
  always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

  // Behavioural datapath: Q8.8 dot product, rows emitted serially.
  beat_t mat [LBEATS];
  beat_t vb  [BEATS];
  int    lcnt = 0, vcnt = 0, orow = 0;
  bit    oact = 1'b0;

  function automatic logic [BITS-1:0] dot_row(input int r);
    longint acc = 0;
    for (int b = 0; b < BEATS; b++)
      for (int m = 0; m < MULTS; m++)
        acc += longint'($signed(mat[AW'(r * BEATS + b)][m])) * longint'($signed(vb[KW'(b)][m]));
    acc = acc >>> 8;
    return acc[BITS-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      lcnt <= 0; vcnt <= 0; oact <= 1'b0; orow <= 0; dp_out_valid <= 1'b0;
    end else begin
      if (dp_load_matrix) begin
        if (lcnt < LBEATS) mat[AW'(lcnt)] <= dp_matrix_a;
        lcnt <= lcnt + 1;
      end else lcnt <= 0;
      if (dp_in_valid) begin
        vb[KW'(vcnt)] <= dp_vector_b;
        if (vcnt == BEATS - 1) begin vcnt <= 0; oact <= 1'b1; orow <= 0; end
        else vcnt <= vcnt + 1;
      end
      dp_out_valid <= oact;
      if (oact) begin
        dp_c <= dot_row(orow);
        if (orow == HEIGHT - 1) oact <= 1'b0;
        orow <= orow + 1;
      end
    end
  end

  function automatic logic [BITS-1:0] elem(input int v, input int j);
    return 16'((v + 1) * 4099 + j * 263 - 20000);
  endfunction

  // Monitor / scoreboard state.
  int    ncyc = 0, ts = 0;
  int    wr_cnt = 0, wr_first = 0, addr_err = 0;
  int    ld_cnt = 0, ld_first = 0, lda_err = 0;
  int    run = 0, vb_err = 0, zero_err = 0, overlap_err = 0;
  int    vr_first = 0, done_cnt = 0, done_t = 0, last_res_t = 0, res_seen = 0;
  int    bursts[$];
  int    istarts[$];
  beat_t beat_q[$];
  res_t  sb_q[$];
  res_t  e;

  always @(negedge clk) begin
    ncyc++;
    if (w_rd_en) begin
      if (wr_cnt == 0) wr_first = ncyc;
      if (int'(w_addr) != wr_cnt) addr_err++;
      wr_cnt++;
    end
    if (dp_load_matrix) begin
      if (ld_cnt == 0) ld_first = ncyc;
      if (ld_cnt >= LBEATS || dp_matrix_a !== wmem[AW'(ld_cnt)]) lda_err++;
      ld_cnt++;
    end else if (dp_matrix_a !== '0) zero_err++;
    if (dp_in_valid) begin
      if (run == 0) istarts.push_back(ncyc);
      run++;
      if (beat_q.size() == 0) vb_err++;
      else begin
        if (dp_vector_b !== beat_q[0]) vb_err++;
        void'(beat_q.pop_front());
      end
    end else begin
      if (run != 0) begin bursts.push_back(run); run = 0; end
      if (dp_vector_b !== '0) zero_err++;
    end
    if (dp_load_matrix && dp_in_valid) overlap_err++;
    if (vec_ready && vr_first == 0) vr_first = ncyc;
    if (done) begin done_cnt++; done_t = ncyc; end
    if (res_valid) begin
      last_res_t = ncyc;
      res_seen++;
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got data %h index %0d with nothing expected", res_data, res_index);
      end else begin
        e = sb_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_index", res_index, e.idx);
      end
    end
  end

  task automatic start_run(input int nv);
    @(negedge clk); #1;
    wr_cnt = 0; ld_cnt = 0; addr_err = 0; lda_err = 0; zero_err = 0; overlap_err = 0;
    vr_first = 0; done_cnt = 0; done_t = 0; last_res_t = 0; vb_err = 0; res_seen = 0; run = 0;
    bursts.delete(); istarts.delete();
    start = 1'b1; n_vectors = 16'(nv); ts = ncyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_vectors(input int nv, input int base, input bit stall, input bit expect_res);
    for (int v = 0; v < nv; v++) begin
      for (int k = 0; k < BEATS; k++) begin
        int    tries = 0;
        bit    acc = 1'b0;
        beat_t b;
        for (int m = 0; m < MULTS; m++) b[m] = elem(base + v, k * MULTS + m);
        while (!acc) begin
          @(negedge clk); #1;
          vec_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          vec_data  = vec_valid ? b : beat_t'($urandom);
          if (vec_valid && vec_ready) begin
            acc = 1'b1;
            beat_q.push_back(b);
          end else begin
            tries++;
            if (tries > 1000) begin fail_now("vec_accept_timeout"); vec_valid = 1'b0; return; end
          end
        end
      end
      if (expect_res)
        for (int r = 0; r < HEIGHT; r++) begin
          res_t x;
          x.data = elem(base + v, r);
          x.idx  = r;
          sb_q.push_back(x);
        end
    end
    @(negedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin @(negedge clk); #1; t++; end
    if (done_cnt == 0) fail_now("done_timeout");
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_run(input int nv, input bit spaced);
    check("w_rd_en_cycles", wr_cnt, LBEATS);
    check("w_rd_en_first", wr_first - ts, 1);
    check("w_addr_seq_errs", addr_err, 0);
    check("load_cycles", ld_cnt, LBEATS);
    check("load_first", ld_first - ts, 2);
    check("matrix_a_errs", lda_err, 0);
    check("zero_drive_errs", zero_err, 0);
    check("load_issue_overlap", overlap_err, 0);
    check("issue_bursts", bursts.size(), nv);
    foreach (bursts[i]) check("burst_len", bursts[i], BEATS);
    check("vector_b_errs", vb_err, 0);
    check("results_seen", res_seen, nv * HEIGHT);
    check("done_pulses", done_cnt, 1);
    if (nv == 0) begin
      check("vec_ready_seen", vr_first, 0);
      check("done_time", done_t - ts, LBEATS + 3);
    end else begin
      check("vec_ready_first", vr_first - ts, LBEATS + 2);
      check("done_after_last_res", done_t - last_res_t, 1);
    end
    if (spaced)
      for (int i = 1; i < istarts.size(); i++) check("issue_spacing", istarts[i] - istarts[i-1], 2 * BEATS);
    check("sb_leftover", sb_q.size(), 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with start asserted.
    rst = 1'b1; start = 1'b1; n_vectors = 16'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_w_rd_en", w_rd_en, 0);
      check("rst_outputs", {done, vec_ready, dp_load_matrix, dp_in_valid, res_valid}, 0);
    end
    check("rst_w_addr", w_addr, 0);
    check("rst_res_index", res_index, 0);
    check("rst_res_data", res_data, 0);
    #1; start = 1'b0; rst = 1'b0;

    // Single vector, no stalls.
    start_run(1); send_vectors(1, 0, 1'b0, 1'b1); wait_done(1000); check_run(1, 1'b0);
    // Single vector with 50% valid stalls.
    start_run(1); send_vectors(1, 1, 1'b1, 1'b1); wait_done(1000); check_run(1, 1'b0);
    // Three vectors back-to-back.
    start_run(3); send_vectors(3, 2, 1'b0, 1'b1); wait_done(1000); check_run(3, 1'b1);
    // Empty run.
    start_run(0); wait_done(1000); check_run(0, 1'b0);

    // Reset during ISSUE beat 7, then a fresh run.
    start_run(1); send_vectors(1, 10, 1'b0, 1'b0);
    for (int t = 0; t < 100 && run != 8; t++) begin @(negedge clk); #1; end
    check("abort_at_beat7", run, 8);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dp_in_valid", dp_in_valid, 0);
    check("abort_dp_load_matrix", dp_load_matrix, 0);
    check("abort_no_done", done_cnt, 0);
    beat_q.delete();
    start_run(1); send_vectors(1, 11, 1'b0, 1'b1); wait_done(1000); check_run(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
